// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, NZCV bit positions and issue FSM state encoding.
package alu_pkg;

    localparam logic [3:0] FN_AND = 4'h0;
    localparam logic [3:0] FN_EOR = 4'h1;
    localparam logic [3:0] FN_SUB = 4'h2;
    localparam logic [3:0] FN_RSB = 4'h3;
    localparam logic [3:0] FN_ADD = 4'h4;
    localparam logic [3:0] FN_ADC = 4'h5;
    localparam logic [3:0] FN_SBC = 4'h6;
    localparam logic [3:0] FN_RSC = 4'h7;
    localparam logic [3:0] FN_TST = 4'h8;
    localparam logic [3:0] FN_TEQ = 4'h9;
    localparam logic [3:0] FN_CMP = 4'hA;
    localparam logic [3:0] FN_CMN = 4'hB;
    localparam logic [3:0] FN_ORR = 4'hC;
    localparam logic [3:0] FN_MOV = 4'hD;
    localparam logic [3:0] FN_BIC = 4'hE;
    localparam logic [3:0] FN_MVN = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } issue_state_t;

    function automatic logic [3:0] pack_nzcv(input logic n, input logic z,
                                             input logic c, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_Z] = z;
        f[FLAG_C] = c;
        f[FLAG_V] = v;
        return f;
    endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// NZCV status register with write enable; shared with condition-code evaluation.
// Latency: one cycle from write enable to output. No backpressure (always writable).
module alu_flag_reg (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_we,
    input  logic [3:0] i_d,
    output logic [3:0] o_q
);

    logic [3:0] r_nzcv;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_nzcv <= 4'b0000;
        end else if (i_we) begin
            r_nzcv <= i_d;
        end
    end

    assign o_q = r_nzcv;

endmodule

// File: rtl/alu_issue_unit.sv
// Issues one op to an external ALU, waits SETTLE cycles, captures result/flags. Optional ALU_ISSUE_STATS_EN adds op/flag counters.
// Latency: response valid SETTLE+1 edges after accept; response held until RSP_READY, new request may overlap the handshake.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic [WIDTH-1:0] REQ_A,
    input  logic [WIDTH-1:0] REQ_B,
    input  logic [3:0]       REQ_FN,
    input  logic             REQ_S,
    input  logic             REQ_USEC,
    output logic [WIDTH-1:0] IL,
    output logic [WIDTH-1:0] IR,
    output logic [3:0]       IF,
    output logic             CIN,
    input  logic [WIDTH-1:0] ALUOUT,
    input  logic             COUT,
    input  logic             N,
    input  logic             V,
    input  logic             ZERO,
    output logic             RSP_VALID,
    input  logic             RSP_READY,
    output logic [WIDTH-1:0] RSP_DATA,
    output logic [3:0]       RSP_FLAGS,
    output logic [3:0]       NZCV
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [15:0]      OP_COUNT,
    output logic [15:0]      FLAG_COUNT
`endif
);

    localparam logic [2:0] CNT_LOAD = 3'(SETTLE - 1);

    issue_state_t     r_state;
    logic [2:0]       r_cnt;
    logic [WIDTH-1:0] r_il;
    logic [WIDTH-1:0] r_ir;
    logic [3:0]       r_if;
    logic             r_cin;
    logic             r_s;
    logic             r_rsp_vld;
    logic [WIDTH-1:0] r_rsp_dat;
    logic [3:0]       r_rsp_flags;

    logic             w_accept;
    logic             w_flag_we;
    logic [3:0]       w_alu_flags;
    logic [3:0]       w_nzcv;

    // Ready in HOLD follows RSP_READY so a new op can start on the handshake edge.
    assign REQ_READY   = RST_N & ((r_state == ST_IDLE) |
                                  ((r_state == ST_HOLD) & RSP_READY));
    assign w_accept    = REQ_VALID & REQ_READY;
    assign w_alu_flags = pack_nzcv(N, ZERO, COUT, V);
    assign w_flag_we   = (r_state == ST_CAPTURE) & r_s;

    alu_flag_reg u_flag_reg (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_we    (w_flag_we),
        .i_d     (w_alu_flags),
        .o_q     (w_nzcv)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 3'd0;
            r_il        <= '0;
            r_ir        <= '0;
            r_if        <= 4'd0;
            r_cin       <= 1'b0;
            r_s         <= 1'b0;
            r_rsp_vld   <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_flags <= 4'd0;
        end else begin
            // Operand registers only change on accept, so they stay stable for the whole op.
            if (w_accept) begin
                r_il  <= REQ_A;
                r_ir  <= REQ_B;
                r_if  <= REQ_FN;
                r_cin <= REQ_USEC ? w_nzcv[FLAG_C] : 1'b0;
                r_s   <= REQ_S;
                r_cnt <= CNT_LOAD;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (r_cnt == 3'd0) begin
                        r_state <= ST_CAPTURE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                ST_CAPTURE: begin
                    r_rsp_dat   <= ALUOUT;
                    r_rsp_flags <= w_alu_flags;
                    r_rsp_vld   <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (RSP_READY) begin
                        r_rsp_vld <= 1'b0;
                        r_state   <= w_accept ? ST_SETTLE : ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign IL        = r_il;
    assign IR        = r_ir;
    assign IF        = r_if;
    assign CIN       = r_cin;
    assign RSP_VALID = r_rsp_vld;
    assign RSP_DATA  = r_rsp_dat;
    assign RSP_FLAGS = r_rsp_flags;
    assign NZCV      = w_nzcv;

`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] r_op_cnt;
    logic [15:0] r_flag_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_op_cnt   <= 16'd0;
            r_flag_cnt <= 16'd0;
        end else begin
            if ((r_state == ST_HOLD) && RSP_READY) begin
                r_op_cnt <= r_op_cnt + 16'd1;
            end
            if (w_flag_we) begin
                r_flag_cnt <= r_flag_cnt + 16'd1;
            end
        end
    end

    assign OP_COUNT   = r_op_cnt;
    assign FLAG_COUNT = r_flag_cnt;
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit (SETTLE=1); the bench itself plays the external ALU.
module tb_alu_issue_unit;
    import alu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        REQ_VALID = 1'b0;
    logic        REQ_READY;
    logic [31:0] REQ_A = '0;
    logic [31:0] REQ_B = '0;
    logic [3:0]  REQ_FN = '0;
    logic        REQ_S = 1'b0;
    logic        REQ_USEC = 1'b0;
    logic [31:0] IL;
    logic [31:0] IR;
    logic [3:0]  IF;
    logic        CIN;
    logic [31:0] ALUOUT = '0;
    logic        COUT = 1'b0;
    logic        N = 1'b0;
    logic        V = 1'b0;
    logic        ZERO = 1'b0;
    logic        RSP_VALID;
    logic        RSP_READY = 1'b0;
    logic [31:0] RSP_DATA;
    logic [3:0]  RSP_FLAGS;
    logic [3:0]  NZCV;
`ifdef ALU_ISSUE_STATS_EN
    logic [15:0] OP_COUNT;
    logic [15:0] FLAG_COUNT;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    alu_issue_unit #(.WIDTH(32), .SETTLE(1)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REQ_VALID (REQ_VALID),
        .REQ_READY (REQ_READY),
        .REQ_A     (REQ_A),
        .REQ_B     (REQ_B),
        .REQ_FN    (REQ_FN),
        .REQ_S     (REQ_S),
        .REQ_USEC  (REQ_USEC),
        .IL        (IL),
        .IR        (IR),
        .IF        (IF),
        .CIN       (CIN),
        .ALUOUT    (ALUOUT),
        .COUT      (COUT),
        .N         (N),
        .V         (V),
        .ZERO      (ZERO),
        .RSP_VALID (RSP_VALID),
        .RSP_READY (RSP_READY),
        .RSP_DATA  (RSP_DATA),
        .RSP_FLAGS (RSP_FLAGS),
        .NZCV      (NZCV)
`ifdef ALU_ISSUE_STATS_EN
        ,
        .OP_COUNT  (OP_COUNT),
        .FLAG_COUNT(FLAG_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_alu(input logic [31:0] res, input logic [3:0] fl);
        ALUOUT = res;
        N      = fl[3];
        ZERO   = fl[2];
        COUT   = fl[1];
        V      = fl[0];
    endtask

    // Accept from IDLE, glitch the ALU during SETTLE, then present the real result.
    task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] fn, input logic s, input logic usec,
                         input logic cin_exp, input logic [31:0] res, input logic [3:0] fl);
        REQ_A = a; REQ_B = b; REQ_FN = fn; REQ_S = s; REQ_USEC = usec;
        REQ_VALID = 1'b1;
        step();
        REQ_VALID = 1'b0;
        check({tag, "_il"}, IL, a);
        check({tag, "_ir"}, IR, b);
        check({tag, "_if"}, {28'd0, IF}, {28'd0, fn});
        check({tag, "_cin"}, {31'd0, CIN}, {31'd0, cin_exp});
        check({tag, "_rdy_busy"}, {31'd0, REQ_READY}, 32'd0);
        set_alu(32'hDEAD_BEEF, ~fl);
        step();
        check({tag, "_not_early"}, {31'd0, RSP_VALID}, 32'd0);
        check({tag, "_cin_held"}, {31'd0, CIN}, {31'd0, cin_exp});
        set_alu(res, fl);
        step();
        check({tag, "_vld"}, {31'd0, RSP_VALID}, 32'd1);
        check({tag, "_data"}, RSP_DATA, res);
        check({tag, "_flags"}, {28'd0, RSP_FLAGS}, {28'd0, fl});
    endtask

    task automatic ack(input string tag);
        RSP_READY = 1'b1;
        step();
        RSP_READY = 1'b0;
        check({tag, "_vld_clr"}, {31'd0, RSP_VALID}, 32'd0);
        check({tag, "_idle_rdy"}, {31'd0, REQ_READY}, 32'd1);
    endtask

    initial begin
        #12;
        check("rst_req_rdy", {31'd0, REQ_READY}, 32'd0);
        check("rst_rsp_vld", {31'd0, RSP_VALID}, 32'd0);
        check("rst_nzcv", {28'd0, NZCV}, 32'd0);
        RST_N = 1'b1;
        step();
        check("idle_rdy", {31'd0, REQ_READY}, 32'd1);

        issue("add", 32'd1, 32'd2, FN_ADD, 1'b1, 1'b0, 1'b0, 32'd3, 4'b0000);
        check("add_nzcv", {28'd0, NZCV}, 32'd0);
        ack("add");

        issue("gate_s0", 32'hFFFF_FFFF, 32'd1, FN_ADD, 1'b0, 1'b0, 1'b0, 32'd0, 4'b0110);
        check("gate_s0_nzcv", {28'd0, NZCV}, 32'd0);
        ack("gate_s0");

        issue("gate_s1", 32'hFFFF_FFFF, 32'd1, FN_ADD, 1'b1, 1'b0, 1'b0, 32'd0, 4'b0110);
        check("gate_s1_nzcv", {28'd0, NZCV}, 32'h6);
        ack("gate_s1");

        issue("usec1", 32'd5, 32'd6, FN_ADC, 1'b0, 1'b1, 1'b1, 32'd12, 4'b0000);
        ack("usec1");
        issue("usec0", 32'd5, 32'd6, FN_ADC, 1'b0, 1'b0, 1'b0, 32'd11, 4'b0000);
        check("usec0_nzcv", {28'd0, NZCV}, 32'h6);

        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_vld", {31'd0, RSP_VALID}, 32'd1);
            check("bp_data", RSP_DATA, 32'd11);
            check("bp_req_rdy", {31'd0, REQ_READY}, 32'd0);
        end

        // Handshake and new accept on the same edge; carry comes from NZCV=0110.
        REQ_A = 32'd7; REQ_B = 32'd9; REQ_FN = FN_SUB; REQ_S = 1'b1; REQ_USEC = 1'b1;
        REQ_VALID = 1'b1;
        RSP_READY = 1'b1;
        #1;
        check("b2b_req_rdy", {31'd0, REQ_READY}, 32'd1);
        step();
        REQ_VALID = 1'b0;
        RSP_READY = 1'b0;
        check("b2b_vld_clr", {31'd0, RSP_VALID}, 32'd0);
        check("b2b_il", IL, 32'd7);
        check("b2b_ir", IR, 32'd9);
        check("b2b_cin", {31'd0, CIN}, 32'd1);
        set_alu(32'hFFFF_FFFE, 4'b1000);
        step();
        step();
        check("b2b_vld", {31'd0, RSP_VALID}, 32'd1);
        check("b2b_data", RSP_DATA, 32'hFFFF_FFFE);
        check("b2b_nzcv", {28'd0, NZCV}, 32'h8);
        ack("b2b");

        // Reset while in SETTLE: op must vanish with no flag update.
        REQ_A = 32'd3; REQ_B = 32'd4; REQ_FN = FN_AND; REQ_S = 1'b1; REQ_USEC = 1'b0;
        REQ_VALID = 1'b1;
        set_alu(32'h55, 4'b1111);
        step();
        REQ_VALID = 1'b0;
        check("mid_il", IL, 32'd3);
        #1;
        RST_N = 1'b0;
        #1;
        check("mrst_il", IL, 32'd0);
        check("mrst_ir", IR, 32'd0);
        check("mrst_if", {28'd0, IF}, 32'd0);
        check("mrst_cin", {31'd0, CIN}, 32'd0);
        check("mrst_vld", {31'd0, RSP_VALID}, 32'd0);
        check("mrst_data", RSP_DATA, 32'd0);
        check("mrst_flags", {28'd0, RSP_FLAGS}, 32'd0);
        check("mrst_nzcv", {28'd0, NZCV}, 32'd0);
        check("mrst_req_rdy", {31'd0, REQ_READY}, 32'd0);
        RST_N = 1'b1;
        step();
        check("post_rst_rdy", {31'd0, REQ_READY}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_no_rsp", {31'd0, RSP_VALID}, 32'd0);
        end
        check("post_rst_nzcv", {28'd0, NZCV}, 32'd0);

`ifdef ALU_ISSUE_STATS_EN
        check("stat_op_rst", {16'd0, OP_COUNT}, 32'd0);
        issue("st1", 32'd1, 32'd1, FN_ADD, 1'b1, 1'b0, 1'b0, 32'd2, 4'b0000);
        ack("st1");
        issue("st2", 32'd2, 32'd2, FN_ADD, 1'b0, 1'b0, 1'b0, 32'd4, 4'b0000);
        ack("st2");
        issue("st3", 32'd3, 32'd3, FN_ADD, 1'b1, 1'b0, 1'b0, 32'd6, 4'b0000);
        ack("st3");
        check("stat_op", {16'd0, OP_COUNT}, 32'd3);
        check("stat_flag", {16'd0, FLAG_COUNT}, 32'd2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_unit.md
Name: alu_issue_unit

Overview:
- Client side of the ALU operand/flag interface. Accepts data-processing requests, drives IL/IR/IF/CIN into an external ALU instance, and waits a fixed settle latency.
- Captures ALUOUT plus the C/N/V/Z flags, updates an architectural NZCV status register, and returns the result on a valid/ready response channel.
- Sits between decode/control and the ALU in the datapath.

Parameters:
- WIDTH, 32, operand/result width; must match the ALU.
- SETTLE, 1, cycles ALU outputs are allowed to settle after operands are driven; legal range 1..7.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ_VALID  in  1  request present.
- REQ_READY  out  1  unit can accept a request.
- REQ_A  in  WIDTH  left operand.
- REQ_B  in  WIDTH  right operand.
- REQ_FN  in  4  ALU function select.
- REQ_S  in  1  update NZCV on completion.
- REQ_USEC  in  1  CIN comes from the stored C flag; otherwise CIN=0.
- IL  out  WIDTH  ALU left operand.
- IR  out  WIDTH  ALU right operand.
- IF  out  4  ALU function select.
- CIN  out  1  ALU carry in.
- ALUOUT  in  WIDTH  ALU result.
- COUT, N, V, ZERO  in  1 each  ALU flags.
- RSP_VALID  out  1  response present.
- RSP_READY  in  1  consumer accepts the response.
- RSP_DATA  out  WIDTH  captured result.
- RSP_FLAGS  out  4  captured {N,Z,C,V} from this operation, regardless of REQ_S.
- NZCV  out  4  architectural flag register {N,Z,C,V}.

Behaviour:
- Reset (async, RST_N=0): state IDLE; IL, IR, RSP_DATA = 0; IF = 0; CIN = 0; RSP_VALID = 0; RSP_FLAGS = 0; NZCV = 0; settle counter = 0. REQ_READY = 0 while RST_N=0.
- Reset mid-operation: any in-flight op is discarded, no flag update, no response.
- FSM states: IDLE, SETTLE, CAPTURE, HOLD.
- IDLE:
  - REQ_READY=1.
  - On REQ_VALID&REQ_READY: register IL=REQ_A, IR=REQ_B, IF=REQ_FN, CIN=REQ_USEC?NZCV[1]:0; latch REQ_S; load counter=SETTLE-1; go to SETTLE.
- SETTLE:
  - REQ_READY=0.
  - Counter decrements each cycle; at 0 go to CAPTURE.
  - IL/IR/IF/CIN are held stable for the whole op.
- CAPTURE (one cycle):
  - RSP_DATA<=ALUOUT; RSP_FLAGS<={N,ZERO,COUT,V}.
  - If latched S, NZCV<={N,ZERO,COUT,V}, otherwise NZCV unchanged.
  - RSP_VALID<=1; go to HOLD.
- HOLD:
  - RSP_VALID=1; RSP_DATA and RSP_FLAGS stable until handshake.
  - On RSP_READY: RSP_VALID<=0, go to IDLE.
  - REQ_READY=RSP_READY in HOLD, so a request may be accepted in the same cycle as the response handshake. In that case go directly to SETTLE with the new operands.
- Carry source for a back-to-back request is the NZCV value already updated by the prior op; NZCV updates in CAPTURE, at least one cycle before any later accept.
- Latency: with SETTLE=1, request accept at edge k gives RSP_VALID=1 after edge k+2. Generally k+SETTLE+1.
- Sustained throughput: one op per SETTLE+2 cycles with RSP_READY held high.
- ALU inputs are sampled only in CAPTURE; glitches during SETTLE are ignored.
- REQ_* are ignored when REQ_READY=0; the requester must hold them while REQ_VALID is asserted.

Optional Feature:
- Macro ALU_ISSUE_STATS_EN.
- When defined, adds outputs OP_COUNT (16 bits, counts completed responses) and FLAG_COUNT (16 bits, counts CAPTUREs with S=1).
- Both counters reset to 0 and wrap at 16'hFFFF -> 0.
- When not defined, the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - 4-bit function-code constants shared with the ALU.
  - Flag bit-index constants: N=3, Z=2, C=1, V=0.
  - State enum encoding IDLE/SETTLE/CAPTURE/HOLD.
- One natural sub-module, alu_flag_reg: NZCV storage with write enable and async active-low reset, reused later by condition-code evaluation.

Test Plan:
- Reset check: assert RST_N=0 mid-SETTLE -> all outputs 0 and NZCV=0000; after release, REQ_READY=1 and no RSP_VALID appears.
- Basic op, SETTLE=1: A=1, B=2, FN=add code, S=1, USEC=0, ALU returns 3 with flags 0 -> RSP_VALID two edges after accept, RSP_DATA=3, NZCV=0000.
- Flag gating: A=32'hFFFFFFFF, B=1, add, S=0 (ALU gives 0, C=1, Z=1) -> RSP_FLAGS=0110, NZCV unchanged. Repeat with S=1 -> NZCV=0110.
- Carry chaining: after NZCV C=1, issue a request with USEC=1 -> CIN=1 driven throughout SETTLE. Same request with USEC=0 -> CIN=0.
- Back-pressure: hold RSP_READY=0 for 5 cycles -> RSP_DATA stable, REQ_READY=0. Then raise RSP_READY with REQ_VALID=1 -> new request accepted in the handshake cycle, IL/IR updated the next edge.
- Stats (ALU_ISSUE_STATS_EN): 3 ops, two with S=1 -> OP_COUNT=3, FLAG_COUNT=2. Preload OP_COUNT near 16'hFFFF via 65536 ops -> wraps to 0.
